// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM handshake states, data word and arbiter FSM states.
package ram_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, wrapping modulo N.
module ram_arbiter_rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o
);

    int            pos;
    logic [PW-1:0] pos_w;

    // Scan from the farthest offset down so the closest requester overwrites last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_w   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_w = PW'(pos);
            if (req_i[pos_w]) begin
                valid_o = 1'b1;
                idx_o   = pos_w;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the d/i cache ports of CPUS cores; one transaction in flight,
// round-robin grants over sources ordered d0,i0,d1,i1,... held until RAM reports ACCESS.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  iload,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]  dstore,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [ADDR_W-1:0]            ramstore,
    input  logic [ADDR_W-1:0]            ramload,
    input  ramstate_t                    ramstate
);

    localparam int NSRC = 2 * CPUS;
    localparam int PW   = $clog2(NSRC);

    logic [NSRC-1:0]             src_req;
    logic [NSRC-1:0]             src_ren;
    logic [NSRC-1:0]             src_wen;
    logic [NSRC-1:0][ADDR_W-1:0] src_addr;
    logic [NSRC-1:0][ADDR_W-1:0] src_store;
    logic [NSRC-1:0]             src_wait;
    logic [NSRC-1:0][ADDR_W-1:0] src_load;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          complete;

    // Flatten the per-core ports into the interleaved source order; WEN overrides REN.
    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_core
            assign src_req[2*gi]     = dREN[gi] | dWEN[gi];
            assign src_ren[2*gi]     = dREN[gi] & ~dWEN[gi];
            assign src_wen[2*gi]     = dWEN[gi];
            assign src_addr[2*gi]    = daddr[gi];
            assign src_store[2*gi]   = dstore[gi];

            assign src_req[2*gi+1]   = iREN[gi];
            assign src_ren[2*gi+1]   = iREN[gi];
            assign src_wen[2*gi+1]   = 1'b0;
            assign src_addr[2*gi+1]  = iaddr[gi];
            assign src_store[2*gi+1] = '0;

            assign dwait[gi] = src_wait[2*gi];
            assign dload[gi] = src_load[2*gi];
            assign iwait[gi] = src_wait[2*gi+1];
            assign iload[gi] = src_load[2*gi+1];
        end

        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic sel;
            assign sel          = complete & (grant_q == PW'(gi));
            assign src_wait[gi] = src_req[gi] & ~sel;
            assign src_load[gi] = sel ? ramload : '0;
        end
    endgenerate

    ram_arbiter_rr_picker #(
        .N  (NSRC),
        .PW (PW)
    ) u_picker (
        .req_i   (src_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        complete = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACTIVE;
                    grant_d = pick_idx;
                end
            end
            ACTIVE: begin
                ramREN   = src_ren[grant_q];
                ramWEN   = src_wen[grant_q];
                ramaddr  = src_addr[grant_q];
                ramstore = src_store[grant_q];
                // A withdrawn request abandons the slot without advancing fairness.
                if (!src_req[grant_q]) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    ptr_d    = (grant_q == PW'(NSRC - 1)) ? '0 : grant_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios, then random traffic against a scoreboard and
// a round-robin reference model driven from the observed request sets.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int NS   = 2 * CPUS;

    logic                     CLK, RST;
    logic [CPUS-1:0]          iREN, iwait, dREN, dWEN, dwait;
    logic [CPUS-1:0][AW-1:0]  iaddr, iload, daddr, dstore, dload;
    logic                     ramREN, ramWEN;
    logic [AW-1:0]            ramaddr, ramstore, ramload, ramload_dir;
    ramstate_t                ramstate;

    bit use_model, mon_en, gen;
    int checks = 0;
    int errors = 0;
    int ncomp  = 0;
    int m_ptr  = 0;

    // Random-phase stimulus state, one slot per source.
    bit          a_act [NS];
    bit          a_wr  [NS];
    bit          a_both[NS];
    logic [31:0] a_addr[NS];
    logic [31:0] a_data[NS];
    bit          done_seen[NS];

    typedef struct {
        int          src;
        logic [31:0] addr;
        logic [31:0] load;
    } exp_t;
    exp_t exp_q[$];
    int   gq[$];

    ram_arbiter #(.CPUS(CPUS), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    assign ramload = use_model ? mem_f(ramaddr) : ramload_dir;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_wait(int s);
        return (s % 2 == 0) ? dwait[s/2] : iwait[s/2];
    endfunction

    function automatic logic [31:0] get_load(int s);
        return (s % 2 == 0) ? dload[s/2] : iload[s/2];
    endfunction

    function automatic logic [3:0] wait_vec();
        logic [3:0] w;
        for (int s = 0; s < NS; s++) w[s] = get_wait(s);
        return w;
    endfunction

    function automatic logic [31:0] src_a(int s);
        return 32'h1000 + 32'(s) * 32'h10;
    endfunction

    // Reference arbitration rule: first requester at or after the pointer, wrapping.
    function automatic int rr_ref(logic [3:0] req, int ptr);
        for (int k = 0; k < NS; k++) begin
            if (req[(ptr + k) % NS]) return (ptr + k) % NS;
        end
        return -1;
    endfunction

    task automatic drive_from_model();
        for (int c = 0; c < CPUS; c++) begin
            dREN[c]   = a_act[2*c] & (~a_wr[2*c] | a_both[2*c]);
            dWEN[c]   = a_act[2*c] & a_wr[2*c];
            daddr[c]  = a_addr[2*c];
            dstore[c] = a_data[2*c];
            iREN[c]   = a_act[2*c+1];
            iaddr[c]  = a_addr[2*c+1];
        end
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    // Scoreboard monitor: samples on the falling edge while the random phase runs.
    always @(negedge CLK) begin
        if (mon_en) begin
            logic [3:0]  req, exp_w;
            logic [31:0] other_or;
            int          g, idx;
            for (int s = 0; s < NS; s++) req[s] = a_act[s];
            if (!(ramREN | ramWEN)) begin
                other_or = '0;
                for (int s = 0; s < NS; s++) other_or |= get_load(s);
                chk("idle_wait", {28'd0, wait_vec()}, {28'd0, req});
                chk("idle_load", other_or, 32'd0);
                if (|req) gq.push_back(rr_ref(req, m_ptr));
            end else if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL active_without_grant: got enable=1 expected no RAM access");
            end else begin
                g = gq[0];
                chk("ramaddr", ramaddr, a_addr[g]);
                chk("ramWEN", {31'd0, ramWEN}, {31'd0, a_wr[g]});
                chk("ramREN", {31'd0, ramREN}, {31'd0, !a_wr[g]});
                if (a_wr[g]) chk("ramstore", ramstore, a_data[g]);
                exp_w = req;
                if (ramstate == ACCESS) exp_w[g] = 1'b0;
                chk("active_wait", {28'd0, wait_vec()}, {28'd0, exp_w});
                other_or = '0;
                for (int s = 0; s < NS; s++) if (s != g) other_or |= get_load(s);
                chk("other_load", other_or, 32'd0);
                if (ramstate == ACCESS) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (exp_q[i].src == g && idx < 0) idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: got completion on src %0d expected none", g);
                    end else begin
                        chk("load", get_load(g), exp_q[idx].load);
                        $display("txn src=%0d addr=%h wr=%0d load=%h", g, exp_q[idx].addr, a_wr[g], get_load(g));
                        exp_q.delete(idx);
                    end
                    void'(gq.pop_front());
                    m_ptr = (g + 1) % NS;
                    done_seen[g] = 1'b1;
                    ncomp++;
                end
            end
        end
    end

    initial begin
        RST = 1'b1; use_model = 1'b0; mon_en = 1'b0; gen = 1'b0;
        clear_inputs();
        ramstate = FREE; ramload_dir = '0;
        for (int s = 0; s < NS; s++) begin
            a_act[s] = 0; a_wr[s] = 0; a_both[s] = 0; a_addr[s] = '0; a_data[s] = '0; done_seen[s] = 0;
        end

        // Reset behaviour.
        #12;
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_waits", {28'd0, wait_vec()}, 32'd0);
        iREN[0] = 1'b1;
        #1;
        chk("rst_iwait0", {31'd0, iwait[0]}, 32'd1);
        @(posedge CLK); #1;
        chk("rst_ramREN_edge", {31'd0, ramREN}, 32'd0);

        // Single read with BUSY x3 then ACCESS.
        iaddr[0] = 32'h100; ramstate = BUSY; RST = 1'b0;
        @(posedge CLK); #1;
        chk("rd_ramREN", {31'd0, ramREN}, 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h100);
        chk("rd_iwait_busy", {31'd0, iwait[0]}, 32'd1);
        repeat (2) begin
            @(posedge CLK); #1;
            chk("rd_iwait_busy", {31'd0, iwait[0]}, 32'd1);
        end
        @(posedge CLK); #1;
        ramstate = ACCESS; ramload_dir = 32'hDEADBEEF;
        #1;
        chk("rd_iwait_done", {31'd0, iwait[0]}, 32'd0);
        chk("rd_iload", iload[0], 32'hDEADBEEF);
        chk("rd_iload_other", iload[1], 32'd0);
        @(posedge CLK); #1;
        iREN[0] = 1'b0; ramstate = FREE;
        #1;
        chk("rd_idle_ramREN", {31'd0, ramREN}, 32'd0);
        $display("txn directed read i0 addr=00000100");

        // Write from d1.
        dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h12345678; ramstate = BUSY;
        #1;
        chk("wr_dwait_idle", {31'd0, dwait[1]}, 32'd1);
        @(posedge CLK); #1;
        chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("wr_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h200);
        chk("wr_ramstore", ramstore, 32'h12345678);
        chk("wr_dwait_busy", {31'd0, dwait[1]}, 32'd1);
        @(posedge CLK); #1;
        ramstate = ACCESS;
        #1;
        chk("wr_dwait_done", {31'd0, dwait[1]}, 32'd0);
        @(posedge CLK); #1;
        dWEN[1] = 1'b0; ramstate = FREE;
        #1;
        chk("wr_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
        $display("txn directed write d1 addr=00000200");

        // Round robin with every source requesting and ACCESS always.
        RST = 1'b1; #1; RST = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            daddr[c] = src_a(2*c); iaddr[c] = src_a(2*c+1);
        end
        dREN = '1; iREN = '1; ramstate = ACCESS; ramload_dir = 32'hCAFE0000;
        #1;
        chk("rr_idle_waits", {28'd0, wait_vec()}, 32'hF);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("rr_grant", {28'd0, wait_vec()}, 32'hF & ~(32'd1 << (k % NS)));
            chk("rr_ramaddr", ramaddr, src_a(k % NS));
            @(posedge CLK); #1;
            chk("rr_bubble", {31'd0, ramREN}, 32'd0);
            $display("txn directed rr grant src=%0d", k % NS);
        end

        // ERROR then withdrawal: no completion and pointer stays at d0.
        RST = 1'b1; #1; RST = 1'b0;
        dREN = 2'b01; iREN = '0; ramstate = ERROR;
        @(posedge CLK); #1;
        chk("err_ramREN", {31'd0, ramREN}, 32'd1);
        chk("err_dwait", {31'd0, dwait[0]}, 32'd1);
        @(posedge CLK); #1;
        chk("err_dwait2", {31'd0, dwait[0]}, 32'd1);
        @(posedge CLK); #1;
        dREN[0] = 1'b0; ramstate = ACCESS;
        #1;
        chk("wd_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wd_dload", dload[0], 32'd0);
        @(posedge CLK); #1;
        dREN[0] = 1'b1; iREN[0] = 1'b1;
        @(posedge CLK); #1;
        chk("wd_next_d0", {28'd0, wait_vec()}, 32'h2);
        $display("txn directed withdraw then d0 grant");

        // Asynchronous reset mid-transaction, then re-arbitration from source 0.
        @(posedge CLK); #1;
        dREN = '0; iREN = 2'b10; ramstate = BUSY;
        @(posedge CLK); #1;
        chk("ar_ramREN", {31'd0, ramREN}, 32'd1);
        chk("ar_ramaddr", ramaddr, src_a(3));
        #2 RST = 1'b1;
        #1;
        chk("ar_ramREN_rst", {31'd0, ramREN}, 32'd0);
        chk("ar_iwait1", {31'd0, iwait[1]}, 32'd1);
        dREN[0] = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; ramstate = ACCESS;
        @(posedge CLK); #1;
        chk("ar_regrant_d0", {28'd0, wait_vec()}, 32'h8);
        chk("ar_ramaddr_d0", ramaddr, src_a(0));
        $display("txn directed async reset then d0 grant");

        // Random traffic against the scoreboard.
        RST = 1'b1; clear_inputs(); ramstate = FREE;
        @(posedge CLK); #1;
        RST = 1'b0; use_model = 1'b1; m_ptr = 0; gen = 1'b1; mon_en = 1'b1;
        for (int cyc = 0; cyc < 1620; cyc++) begin
            if (cyc == 1500) gen = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (done_seen[s]) begin
                    done_seen[s] = 1'b0;
                    a_act[s] = 1'b0;
                end
                if (gen && !a_act[s] && $urandom_range(0, 2) == 0) begin
                    a_act[s]  = 1'b1;
                    a_addr[s] = $urandom;
                    a_data[s] = $urandom;
                    a_wr[s]   = (s % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    a_both[s] = a_wr[s] & 1'($urandom_range(0, 1));
                    exp_q.push_back('{src: s, addr: a_addr[s], load: mem_f(a_addr[s])});
                end
            end
            drive_from_model();
            if (gen) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: ramstate = ACCESS;
                    4, 5:       ramstate = BUSY;
                    6, 7:       ramstate = FREE;
                    default:    ramstate = ERROR;
                endcase
            end else begin
                ramstate = ACCESS;
            end
            @(posedge CLK); #1;
        end
        mon_en = 1'b0;
        chk("drain_expected", 32'(exp_q.size()), 32'd0);
        chk("drain_grants", 32'(gq.size()), 32'd0);
        chk("completions_seen", {31'd0, ncomp > 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
